// File: rtl/grant_data_mux.sv
// Grant-driven data mux: accepts one beat from the one-hot granted requester,
// tags it with its index and queues it in a small FIFO behind a valid/ready port.
// Optional macro GDM_TENURE_CNT_EN adds a per-grant tenure counter on tenure_beats.
module grant_data_mux #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            GNT,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ack,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic                  fifo_full,
  output logic                  gnt_err
`ifdef GDM_TENURE_CNT_EN
  ,output logic [7:0]           tenure_beats
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]        src;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t          mem [DEPTH];
  beat_t          head;
  beat_t          in_beat;
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [AW:0]    count, count_next;
  logic [2:0]     ones;
  logic [1:0]     sel;
  logic           gnt_ok, push, pop, head_from_in;

  // Grant decode: population count and index of the (last) set bit.
  always_comb begin
    ones = 3'd0;
    sel  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (GNT[i]) begin
        ones = ones + 3'd1;
        sel  = 2'(i);
      end
    end
  end

  assign gnt_ok  = (ones == 3'd1);
  // NOTE: rst gates push so req_ack drops combinationally while reset is held.
  assign push    = !rst && gnt_ok && req_valid[sel] && !fifo_full;
  assign pop     = out_valid && out_ready;
  assign req_ack = push ? (4'b0001 << sel) : 4'b0000;

  assign in_beat.src  = sel;
  assign in_beat.data = req_data[sel*DATA_W +: DATA_W];

  assign rd_next      = rd_ptr + AW'(pop);
  assign count_next   = count + (AW+1)'(push) - (AW+1)'(pop);
  // FIFO empty once this cycle's pop is taken: the new head is this cycle's push.
  assign head_from_in = (count == (AW+1)'(pop));

  // NOTE: storage carries no reset; validity is tracked by count, so stale
  // entries are never observable and the array can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      fifo_full <= 1'b0;
      head      <= '0;
      gnt_err   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      fifo_full <= (count_next == FULL_CNT);
      if (count_next != '0)
        head <= head_from_in ? in_beat : mem[rd_next];
      if (ones >= 3'd2)
        gnt_err <= 1'b1;
    end
  end

  assign out_src  = head.src;
  assign out_data = head.data;

`ifdef GDM_TENURE_CNT_EN
  logic [3:0] prev_gnt;
  logic [7:0] tenure_cnt;
  logic [8:0] cnt_sum;
  logic [7:0] cnt_sat;

  assign cnt_sum = {1'b0, tenure_cnt} + 9'(push);
  assign cnt_sat = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

  // A grant change closes the current tenure, including that cycle's push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gnt     <= 4'b0000;
      tenure_cnt   <= 8'd0;
      tenure_beats <= 8'd0;
    end else begin
      prev_gnt <= GNT;
      if (GNT != prev_gnt) begin
        tenure_beats <= cnt_sat;
        tenure_cnt   <= 8'd0;
      end else begin
        tenure_cnt   <= cnt_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grant_data_mux.sv
// Directed bench for grant_data_mux: reset, single beat, backpressure, wrap,
// illegal grant and (with GDM_TENURE_CNT_EN) tenure measurement.
module tb_grant_data_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  GNT;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        fifo_full;
  logic        gnt_err;
`ifdef GDM_TENURE_CNT_EN
  logic [7:0]  tenure_beats;
`endif

  int total = 0;
  int bad   = 0;

  grant_data_mux #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .GNT       (GNT),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .fifo_full (fifo_full),
    .gnt_err   (gnt_err)
`ifdef GDM_TENURE_CNT_EN
    ,.tenure_beats (tenure_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int j, input logic [7:0] v);
    req_data[j*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; GNT = 4'b0001; req_valid = 4'hF;
    req_data = 32'h44332211;
    #2;
    total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL rst_ack: got %b expected 0000", req_ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    total++; if (fifo_full !== 1'b0 || gnt_err !== 1'b0) begin bad++; $display("FAIL rst_flags: got full=%b err=%b expected 0 0", fifo_full, gnt_err); end
    total++; if (out_data !== 8'h00 || out_src !== 2'd0) begin bad++; $display("FAIL rst_head: got %h/%0d expected 00/0", out_data, out_src); end
    step();
    rst = 1'b0;
    #1;
    total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL release_ack: got %b expected 0001", req_ack); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd0) begin bad++; $display("FAIL release_push: got v=%b %h/%0d expected 1 11/0", out_valid, out_data, out_src); end
    GNT = 4'b0000; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h11) begin bad++; $display("FAIL empty_hold: got v=%b d=%h expected 0 11", out_valid, out_data); end
  endtask

  task automatic test_single();
    GNT = 4'b0100; req_valid = 4'b0100; set_lane(2, 8'hA5); out_ready = 1'b1;
    #1;
    total++; if (req_ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b expected 0100", req_ack); end
    step();
    GNT = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin bad++; $display("FAIL single_out: got v=%b %h/%0d expected 1 a5/2", out_valid, out_data, out_src); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop: got %b expected 0", out_valid); end
  endtask

  task automatic test_full();
    out_ready = 1'b0; GNT = 4'b0001; req_valid = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      set_lane(0, 8'(i));
      #1;
      total++; if (req_ack !== ((i <= 4) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL full_ack%0d: got %b expected %b", i, req_ack, (i <= 4) ? 4'b0001 : 4'b0000); end
      step();
    end
    total++; if (fifo_full !== 1'b1 || out_data !== 8'd1) begin bad++; $display("FAIL full_state: got full=%b d=%h expected 1 01", fifo_full, out_data); end
    out_ready = 1'b1; set_lane(0, 8'd7);
    #1;
    total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL full_no_bypass: got %b expected 0000", req_ack); end
    step();
    total++; if (fifo_full !== 1'b0 || out_data !== 8'd2) begin bad++; $display("FAIL full_drop: got full=%b d=%h expected 0 02", fifo_full, out_data); end
    #1;
    total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL full_resume: got %b expected 0001", req_ack); end
    step();
    GNT = 4'b0000;
    total++; if (out_data !== 8'd3) begin bad++; $display("FAIL drain3: got %h expected 03", out_data); end
    step();
    total++; if (out_data !== 8'd4) begin bad++; $display("FAIL drain4: got %h expected 04", out_data); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'd7) begin bad++; $display("FAIL drain7: got v=%b d=%h expected 1 07", out_valid, out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    out_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      g = 4'b0001 << (i % 4);
      GNT = g;
      for (int j = 0; j < 4; j++) set_lane(j, 8'(i*16 + j));
      #1;
      total++; if (req_ack !== g) begin bad++; $display("FAIL wrap_ack%0d: got %b expected %b", i, req_ack, g); end
      step();
      total++; if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== 8'(i*16 + i % 4)) begin bad++; $display("FAIL wrap_out%0d: got v=%b %h/%0d expected 1 %h/%0d", i, out_valid, out_data, out_src, 8'(i*16 + i % 4), i % 4); end
    end
    GNT = 4'b0000;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_no_valid();
    GNT = 4'b0010; req_valid = 4'b0001;
    #1;
    total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL novalid_ack: got %b expected 0000", req_ack); end
    step();
    total++; if (out_valid !== 1'b0 || gnt_err !== 1'b0) begin bad++; $display("FAIL novalid_state: got v=%b err=%b expected 0 0", out_valid, gnt_err); end
  endtask

  task automatic test_illegal();
    GNT = 4'b0011; req_valid = 4'hF; set_lane(0, 8'h5C);
    #1;
    total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL illegal_ack: got %b expected 0000", req_ack); end
    step();
    total++; if (gnt_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL illegal_err: got err=%b v=%b expected 1 0", gnt_err, out_valid); end
    GNT = 4'b0001; out_ready = 1'b0;
    step();
    total++; if (gnt_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h5C) begin bad++; $display("FAIL illegal_sticky: got err=%b v=%b d=%h expected 1 1 5c", gnt_err, out_valid, out_data); end
    rst = 1'b1;
    #1;
    total++; if (req_ack !== 4'b0000 || out_valid !== 1'b0 || gnt_err !== 1'b0) begin bad++; $display("FAIL midreset: got ack=%b v=%b err=%b expected 0000 0 0", req_ack, out_valid, gnt_err); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL midreset_data: got %h expected 00", out_data); end
    step();
    GNT = 4'b0000; rst = 1'b0;
  endtask

`ifdef GDM_TENURE_CNT_EN
  task automatic test_tenure();
    rst = 1'b1; GNT = 4'b0000;
    #1;
    total++; if (tenure_beats !== 8'd0) begin bad++; $display("FAIL tenure_rst: got %0d expected 0", tenure_beats); end
    step();
    rst = 1'b0; GNT = 4'b1000; req_valid = 4'b1001; out_ready = 1'b1;
    step(); step(); step();
    GNT = 4'b0001;
    step();
    total++; if (tenure_beats !== 8'd3) begin bad++; $display("FAIL tenure: got %0d expected 3", tenure_beats); end
    GNT = 4'b0000;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_no_valid();
    test_illegal();
`ifdef GDM_TENURE_CNT_EN
    test_tenure();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grant_data_mux.md
# grant_data_mux

Downstream consumer of the 4-requester round-robin arbiter's one-hot `GNT`. Each cycle it takes one data beat from the granted requester and acknowledges it. It tags the beat with the requester index and buffers it in a small FIFO. The beat is then presented on a valid/ready output port. It also flags illegal (multi-hot) grants and, optionally, measures grant tenure per requester.

## Interface
- `DATA_W`, 8: width of each requester's data beat.
- `DEPTH`, 4: output FIFO entries. Must be a power of 2, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `GNT`  in  4  one-hot grant from arbiter. 4'b0000 = idle.
- `req_valid`  in  4  per-requester beat available.
- `req_data`  in  4*DATA_W  requester i data on bits [i*DATA_W +: DATA_W].
- `req_ack`  out  4  combinational. Beat from requester i accepted this cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  DATA_W  FIFO head data.
- `out_src`  out  2  FIFO head requester index.
- `out_ready`  in  1  consumer accepts head.
- `fifo_full`  out  1  registered, count == DEPTH.
- `gnt_err`  out  1  sticky illegal-grant flag.
- `tenure_beats`  out  8  present only with `GDM_TENURE_CNT_EN` (see Configuration).

## Operation
- `gnt_ok` = `GNT` has exactly one bit set. `sel` = index of that bit.
- Push condition: `gnt_ok && req_valid[sel] && !fifo_full`.
  - On push: write {sel, data of sel} at the write pointer, and set `req_ack[sel]`=1.
  - All other `req_ack` bits are 0.
- `req_ack` is 0 whenever `rst` is high, `GNT`==0, `GNT` is multi-hot, or `fifo_full`.
- Pop condition: `out_valid && out_ready`. The read pointer advances.
- FIFO state:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
- Full boundary: no push when full, even if a pop occurs the same cycle (no bypass). Push resumes the cycle after `fifo_full` drops.
- Empty boundary:
  - `out_valid`=0.
  - `out_data`/`out_src` hold their last value; after reset they hold 0.
  - No write-through: a beat pushed into an empty FIFO is not visible until the next cycle.
- Illegal grant (popcount(`GNT`) ≥2):
  - No push, no ack.
  - `gnt_err` is set on the next edge and stays set until `rst`.
  - FIFO operation otherwise continues.
- Granted requester with `req_valid`=0: no push, no error.

## Timing
- Reset values (async, immediate):
  - `out_valid`=0, `out_data`=0, `out_src`=0, `fifo_full`=0, `gnt_err`=0.
  - Pointers and count are 0. `tenure_beats`=0.
- Ack-to-output latency: a beat acked in cycle N appears on `out_valid`/`out_data` in cycle N+1 if the FIFO was empty.
- Throughput: one beat per cycle while not full and `out_ready`=1.
- `fifo_full` and `out_valid` are registered, derived from the post-edge count.
- Reset asserted mid-transfer:
  - FIFO contents are discarded and `out_valid` drops at once.
  - `req_ack` goes to 0 combinationally.
- Reset release: the first push is possible on the first rising edge with `rst`=0.

## Configuration
- Macro: `GDM_TENURE_CNT_EN`.
- Defined:
  - An internal 8-bit saturating counter counts pushes from `sel` while `GNT` stays equal to its previous-cycle value.
  - When `GNT` changes (any change, including to 0), the counter value, plus the push of that cycle if any, is latched into `tenure_beats`, and the counter restarts at 0.
  - Saturates at 255.
- Not defined: the `tenure_beats` port, the counter and the previous-GNT register are absent. All other behaviour is identical.

## Test plan
- Reset then idle: `rst`=1 with `GNT`=4'b0001, `req_valid`=4'hF. Result: `req_ack`=0 and `out_valid`=0. After release, the first edge pushes requester 0.
- Single beat:
  - Stimulus: `GNT`=4'b0100, `req_valid`=4'b0100, `req_data[2]`=8'hA5, `out_ready`=1.
  - Result: `req_ack`=4'b0100 in the same cycle. Next cycle `out_valid`=1, `out_data`=8'hA5, `out_src`=2. Popped the following edge.
- Full / backpressure:
  - Stimulus: `out_ready`=0, `GNT`=4'b0001, `req_valid`=4'b0001 for 6 cycles, data 1..6.
  - Result: 4 acks, then `fifo_full`=1 and `req_ack`=0. Raising `out_ready` drains 1,2,3,4 in order, with pushes resuming after `fifo_full` drops.
- Wrap-around: 10 back-to-back beats with `out_ready`=1 and rotating `GNT` 1→2→4→8. `out_src` sequence is 0,1,2,3,…, with data intact across pointer wrap.
- Illegal grant: `GNT`=4'b0011 for one cycle with `req_valid`=4'hF. Result: no ack, `gnt_err`=1 next cycle. `gnt_err` stays 1 after `GNT` returns legal, and clears only on `rst`.
- Tenure (macro defined): `GNT`=4'b1000 for 3 cycles with `req_valid[3]`=1, `out_ready`=1, then `GNT`=4'b0001. Result: `tenure_beats`=3 the cycle after the change.
